// File: rtl/conv_stream_engine.sv
// Streaming 3x3 convolution engine: two line buffers feed a sliding window,
// OUT_CH parallel lanes apply per-channel weights and bias, with stride 1/2 and ReLU.

module conv_stream_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic [8:0][DATA_W-1:0] taps_i,
    input  logic [8:0][DATA_W-1:0] w_i,
    input  logic [DATA_W-1:0]      bias_i,
    input  logic                   relu_i,
    output logic [ACC_W-1:0]       res_o
);
    logic signed [ACC_W-1:0] acc;

    // Pixels are unsigned (zero-extend), weights and bias are signed (sign-extend).
    always_comb begin
        acc = ACC_W'($signed(bias_i));
        for (int t = 0; t < 9; t++) begin
            acc = acc + ACC_W'($signed(w_i[t])) * $signed({{(ACC_W-DATA_W){1'b0}}, taps_i[t]});
        end
        res_o = (relu_i && acc[ACC_W-1]) ? '0 : acc;
    end
endmodule

module conv_stream_engine #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8,
    parameter int OUT_CH = 2,
    parameter int ACC_W  = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cfg_we,
    input  logic [$clog2(OUT_CH*10)-1:0]  i_cfg_addr,
    input  logic [DATA_W-1:0]             i_cfg_data,
    input  logic                          i_relu_en,
    input  logic                          i_stride2,
    input  logic                          i_pre_valid,
    output logic                          o_pre_ready,
    input  logic [DATA_W-1:0]             i_data,
    output logic                          o_post_valid,
    input  logic                          i_post_ready,
    output logic [OUT_CH*ACC_W-1:0]       o_res,
    output logic                          o_last
);
    localparam int AW = $clog2(OUT_CH*10);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NW = OUT_CH*9;
    // In stride-2 mode the final window sits on the last row/col with even offset from 2.
    localparam int LAST_ROW_S2 = ((IMG_H-3) % 2 == 0) ? IMG_H-1 : IMG_H-2;
    localparam int LAST_COL_S2 = ((IMG_W-3) % 2 == 0) ? IMG_W-1 : IMG_W-2;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          relu_q, s2_q;
    logic          vld_q, last_q;
    logic [OUT_CH-1:0][ACC_W-1:0] res_q;
    logic [NW-1:0][DATA_W-1:0]     w_q;
    logic [OUT_CH-1:0][DATA_W-1:0] b_q;

    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [2:0][1:0][DATA_W-1:0] win_q;

    logic beat, col_end, row_end, frame_start, win_ok, last_hit;
    logic [8:0][DATA_W-1:0]      taps;
    logic [OUT_CH-1:0][ACC_W-1:0] lane_res;

    assign o_pre_ready  = !vld_q || i_post_ready;
    assign beat         = i_pre_valid && o_pre_ready;
    assign col_end      = (col_q == CW'(IMG_W-1));
    assign row_end      = (row_q == RW'(IMG_H-1));
    assign frame_start  = (row_q == '0) && (col_q == '0);
    assign win_ok       = (row_q >= RW'(2)) && (col_q >= CW'(2)) &&
                          (!s2_q || (!row_q[0] && !col_q[0]));
    assign last_hit     = s2_q ? ((row_q == RW'(LAST_ROW_S2)) && (col_q == CW'(LAST_COL_S2)))
                               : (row_end && col_end);
    assign o_post_valid = vld_q;
    assign o_res        = res_q;
    assign o_last       = last_q;

    // Columns col-2 and col-1 come from the window shift regs; column col is read live.
    always_comb begin
        for (int dy = 0; dy < 3; dy++) begin
            taps[3*dy]   = win_q[dy][0];
            taps[3*dy+1] = win_q[dy][1];
        end
        taps[2] = lb2_q[col_q];
        taps[5] = lb1_q[col_q];
        taps[8] = i_data;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (beat) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    for (genvar k = 0; k < OUT_CH; k++) begin : g_lane
        conv_stream_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .taps_i (taps),
            .w_i    (w_q[k*9 +: 9]),
            .bias_i (b_q[k]),
            .relu_i (relu_q),
            .res_o  (lane_res[k])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            relu_q <= 1'b0;
            s2_q   <= 1'b0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            res_q  <= '0;
            w_q    <= '0;
            b_q    <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (beat && frame_start) begin
                relu_q <= i_relu_en;
                s2_q   <= i_stride2;
            end
            if (beat && win_ok) begin
                vld_q  <= 1'b1;
                res_q  <= lane_res;
                last_q <= last_hit;
            end else if (i_post_ready) begin
                vld_q  <= 1'b0;
            end
            if (i_cfg_we) begin
                for (int k = 0; k < NW; k++)
                    if (i_cfg_addr == AW'(k)) w_q[k] <= i_cfg_data;
                for (int k = 0; k < OUT_CH; k++)
                    if (i_cfg_addr == AW'(NW+k)) b_q[k] <= i_cfg_data;
            end
        end
    end

    // Buffer contents need no reset: counters keep stale entries out of any window.
    always_ff @(posedge i_clk) begin
        if (beat) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= i_data;
            for (int dy = 0; dy < 3; dy++) begin
                win_q[dy][0] <= win_q[dy][1];
                win_q[dy][1] <= taps[3*dy+2];
            end
        end
    end
endmodule

// File: tb/tb_conv_stream_engine.sv
// Randomized bench for conv_stream_engine: an image-level reference model
// computes every expected window result, compared in order against the DUT.

module tb_conv_stream_engine;
    localparam int W = 28, H = 28, N = W*H, DW = 8, OC = 2, AW = 32;
    localparam int CA = $clog2(OC*10);

    logic            i_clk, i_rst_n, i_cfg_we, i_relu_en, i_stride2;
    logic [CA-1:0]   i_cfg_addr;
    logic [DW-1:0]   i_cfg_data, i_data;
    logic            i_pre_valid, o_pre_ready, o_post_valid, i_post_ready, o_last;
    logic [OC*AW-1:0] o_res;

    conv_stream_engine #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .OUT_CH(OC), .ACC_W(AW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
        .i_cfg_data(i_cfg_data), .i_relu_en(i_relu_en), .i_stride2(i_stride2),
        .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready), .i_data(i_data),
        .o_post_valid(o_post_valid), .i_post_ready(i_post_ready), .o_res(o_res), .o_last(o_last)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_bad = 0;
    int img [N];
    int w_m [OC][9];
    int b_m [OC];
    int e0[$], e1[$];
    bit el[$];
    logic [31:0] o0[$], o1[$];
    bit ol[$];

    function automatic void build_model(bit s2, bit relu);
        int s;
        e0.delete(); e1.delete(); el.delete();
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) begin
                if (s2 && (((r-2) % 2 != 0) || ((c-2) % 2 != 0))) continue;
                for (int k = 0; k < OC; k++) begin
                    s = b_m[k];
                    for (int dy = 0; dy < 3; dy++)
                        for (int dx = 0; dx < 3; dx++)
                            s += w_m[k][3*dy+dx] * img[(r-2+dy)*W + (c-2+dx)];
                    if (relu && s < 0) s = 0;
                    if (k == 0) e0.push_back(s); else e1.push_back(s);
                end
                el.push_back(1'b0);
            end
        if (el.size() > 0) el[el.size()-1] = 1'b1;
    endfunction

    task automatic cfg_write(input int addr, input int data);
        @(posedge i_clk); #1;
        i_cfg_we = 1'b1; i_cfg_addr = CA'(addr); i_cfg_data = DW'(data);
        @(posedge i_clk); #1;
        i_cfg_we = 1'b0;
    endtask

    task automatic load_cfg();
        for (int k = 0; k < OC; k++)
            for (int t = 0; t < 9; t++) cfg_write(k*9+t, w_m[k][t]);
        for (int k = 0; k < OC; k++) cfg_write(OC*9+k, b_m[k]);
    endtask

    task automatic set_ramp_cfg();
        for (int t = 0; t < 9; t++) begin w_m[0][t] = t; w_m[1][t] = 1; end
        b_m[0] = 1; b_m[1] = 0;
        load_cfg();
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r*W+c] = c;
    endtask

    // Streams img[]; records every accepted result. Optional pixel abort and result hold.
    task automatic run_frame(input int pv, input int pr, input int abort_at, input int hold,
                             input bit scramble, output bit to, output bit hold_ok,
                             output logic [31:0] held0);
        int idx = 0, cyc = 0, tail = 0;
        bit holding, captured = 1'b0, m_relu = i_relu_en, m_s2 = i_stride2;
        o0.delete(); o1.delete(); ol.delete();
        to = 1'b0; hold_ok = 1'b1; held0 = '0;
        forever begin
            @(posedge i_clk); #1;
            i_pre_valid = (idx < N) && ($urandom_range(0, 99) < pv);
            i_data = DW'(img[(idx < N) ? idx : 0]);
            if (scramble && idx > 0) begin
                i_relu_en = 1'($urandom); i_stride2 = 1'($urandom);
            end
            holding = (hold > 0) && o_post_valid;
            if (holding) begin
                if (!captured) begin held0 = o_res[31:0]; captured = 1'b1; end
                hold--;
                i_post_ready = 1'b0;
            end else begin
                i_post_ready = ($urandom_range(0, 99) < pr);
            end
            @(negedge i_clk);
            if (holding && (o_res[31:0] !== held0 || o_pre_ready !== 1'b0)) hold_ok = 1'b0;
            if (o_post_valid && i_post_ready) begin
                o0.push_back(o_res[31:0]); o1.push_back(o_res[63:32]); ol.push_back(o_last);
            end
            if (i_pre_valid && o_pre_ready) idx++;
            cyc++;
            if (abort_at >= 0 && idx >= abort_at) break;
            tail = (idx >= N && !o_post_valid) ? tail + 1 : 0;
            if (tail >= 3) break;
            if (cyc > 20000) begin to = 1'b1; break; end
        end
        i_pre_valid = 1'b0; i_post_ready = 1'b0;
        i_relu_en = m_relu; i_stride2 = m_s2;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
        i_relu_en = 1'b0; i_stride2 = 1'b0; i_pre_valid = 1'b0; i_data = '0; i_post_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        n_cmp++;
        if ({o_post_valid, o_last, o_res, o_pre_ready} !== {2'b00, {(OC*AW){1'b0}}, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%0b last=%0b res=%h ready=%0b, expected 0 0 0 1",
                     o_post_valid, o_last, o_res, o_pre_ready);
        end
        @(posedge i_clk); #1 i_rst_n = 1'b1;
    endtask

    task automatic test_stride1();
        bit to, hok; logic [31:0] h0;
        fill_ramp(); set_ramp_cfg();
        i_relu_en = 1'b0; i_stride2 = 1'b0;
        build_model(1'b0, 1'b0);
        run_frame(100, 100, -1, 0, 1'b0, to, hok, h0);
        n_cmp++;
        if (to || o0.size() != e0.size()) begin
            n_bad++; $display("FAIL s1_count: got %0d (timeout=%0b), expected %0d", o0.size(), to, e0.size());
        end
        for (int i = 0; i < e0.size() && i < o0.size(); i++) begin
            n_cmp++;
            if ({o0[i], o1[i], ol[i]} !== {32'(e0[i]), 32'(e1[i]), el[i]}) begin
                n_bad++;
                $display("FAIL s1_result[%0d]: got %0d/%0d last=%0b, expected %0d/%0d last=%0b",
                         i, $signed(o0[i]), $signed(o1[i]), ol[i], e0[i], e1[i], el[i]);
            end
        end
        if (o0.size() > 25) begin
            n_cmp++;
            if (o0[0] !== 32'd43 || o0[25] !== 32'd943 || o1[25] !== 32'd234) begin
                n_bad++;
                $display("FAIL s1_row0: got %0d,%0d,%0d expected 43,943,234", o0[0], o0[25], o1[25]);
            end
        end
    endtask

    task automatic test_stride2();
        bit to, hok; logic [31:0] h0;
        for (int a = OC*10; a < (1 << CA); a++) cfg_write(a, 8'h55);
        i_relu_en = 1'b0; i_stride2 = 1'b1;
        build_model(1'b1, 1'b0);
        run_frame(100, 100, -1, 0, 1'b1, to, hok, h0);
        n_cmp++;
        if (to || o0.size() != e0.size()) begin
            n_bad++; $display("FAIL s2_count: got %0d (timeout=%0b), expected %0d", o0.size(), to, e0.size());
        end
        for (int i = 0; i < e0.size() && i < o0.size(); i++) begin
            n_cmp++;
            if ({o0[i], o1[i], ol[i]} !== {32'(e0[i]), 32'(e1[i]), el[i]}) begin
                n_bad++;
                $display("FAIL s2_result[%0d]: got %0d/%0d last=%0b, expected %0d/%0d last=%0b",
                         i, $signed(o0[i]), $signed(o1[i]), ol[i], e0[i], e1[i], el[i]);
            end
        end
        if (o0.size() > 12) begin
            n_cmp++;
            if (o0[1] !== 32'd115 || o0[12] !== 32'd907) begin
                n_bad++; $display("FAIL s2_row0: got %0d,%0d expected 115,907", o0[1], o0[12]);
            end
        end
        i_stride2 = 1'b0;
    endtask

    task automatic test_relu();
        bit to, hok; logic [31:0] h0;
        for (int t = 0; t < 9; t++) w_m[0][t] = -1;
        b_m[0] = 0;
        load_cfg();
        for (int m = 0; m < 2; m++) begin
            i_relu_en = 1'(m); i_stride2 = 1'b0;
            build_model(1'b0, 1'(m));
            run_frame(100, 100, -1, 0, 1'b0, to, hok, h0);
            n_cmp++;
            if (to || o0.size() != e0.size()) begin
                n_bad++; $display("FAIL relu%0d_count: got %0d, expected %0d", m, o0.size(), e0.size());
            end
            for (int i = 0; i < e0.size() && i < o0.size(); i++) begin
                n_cmp++;
                if ({o0[i], o1[i], ol[i]} !== {32'(e0[i]), 32'(e1[i]), el[i]}) begin
                    n_bad++;
                    $display("FAIL relu%0d_result[%0d]: got %0d/%0d last=%0b, expected %0d/%0d last=%0b",
                             m, i, $signed(o0[i]), $signed(o1[i]), ol[i], e0[i], e1[i], el[i]);
                end
            end
            if (o0.size() > 0) begin
                n_cmp++;
                if (o0[0] !== ((m == 0) ? 32'hFFFF_FFF7 : 32'h0)) begin
                    n_bad++; $display("FAIL relu%0d_first: got %h", m, o0[0]);
                end
            end
        end
        i_relu_en = 1'b0;
    endtask

    task automatic test_backpressure();
        bit to, hok; logic [31:0] h0;
        set_ramp_cfg();
        i_relu_en = 1'b0; i_stride2 = 1'b0;
        build_model(1'b0, 1'b0);
        run_frame(100, 100, -1, 20, 1'b0, to, hok, h0);
        n_cmp++;
        if (!hok || h0 !== 32'd43) begin
            n_bad++; $display("FAIL bp_hold: got stable=%0b held=%0d, expected 1 and 43", hok, h0);
        end
        n_cmp++;
        if (to || o0.size() != e0.size()) begin
            n_bad++; $display("FAIL bp_count: got %0d, expected %0d", o0.size(), e0.size());
        end
        for (int i = 0; i < e0.size() && i < o0.size(); i++) begin
            n_cmp++;
            if ({o0[i], o1[i], ol[i]} !== {32'(e0[i]), 32'(e1[i]), el[i]}) begin
                n_bad++;
                $display("FAIL bp_result[%0d]: got %0d/%0d last=%0b, expected %0d/%0d last=%0b",
                         i, $signed(o0[i]), $signed(o1[i]), ol[i], e0[i], e1[i], el[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to, hok; logic [31:0] h0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
            for (int k = 0; k < OC; k++) begin
                for (int t = 0; t < 9; t++) w_m[k][t] = int'($urandom_range(0, 255)) - 128;
                b_m[k] = int'($urandom_range(0, 255)) - 128;
            end
            load_cfg();
            i_stride2 = 1'(f); i_relu_en = 1'(f == 0);
            build_model(1'(f), 1'(f == 0));
            run_frame(50, 50, -1, 0, 1'b1, to, hok, h0);
            n_cmp++;
            if (to || o0.size() != e0.size()) begin
                n_bad++; $display("FAIL rand%0d_count: got %0d, expected %0d", f, o0.size(), e0.size());
            end
            for (int i = 0; i < e0.size() && i < o0.size(); i++) begin
                n_cmp++;
                if ({o0[i], o1[i], ol[i]} !== {32'(e0[i]), 32'(e1[i]), el[i]}) begin
                    n_bad++;
                    $display("FAIL rand%0d_result[%0d]: got %0d/%0d last=%0b, expected %0d/%0d last=%0b",
                             f, i, $signed(o0[i]), $signed(o1[i]), ol[i], e0[i], e1[i], el[i]);
                end
            end
        end
        i_stride2 = 1'b0; i_relu_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        bit to, hok; logic [31:0] h0;
        fill_ramp(); set_ramp_cfg();
        i_relu_en = 1'b0; i_stride2 = 1'b0;
        run_frame(100, 50, 300, 0, 1'b0, to, hok, h0);
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_post_valid, o_last, o_res} !== {2'b00, {(OC*AW){1'b0}}}) begin
            n_bad++; $display("FAIL midrst_out: got valid=%0b last=%0b res=%h, expected 0", o_post_valid, o_last, o_res);
        end
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int k = 0; k < OC; k++) begin
            for (int t = 0; t < 9; t++) w_m[k][t] = 0;
            b_m[k] = 0;
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) set_ramp_cfg();
            build_model(1'b0, 1'b0);
            run_frame(100, 100, -1, 0, 1'b0, to, hok, h0);
            n_cmp++;
            if (to || o0.size() != e0.size()) begin
                n_bad++; $display("FAIL midrst%0d_count: got %0d, expected %0d", pass, o0.size(), e0.size());
            end
            for (int i = 0; i < e0.size() && i < o0.size(); i++) begin
                n_cmp++;
                if ({o0[i], o1[i], ol[i]} !== {32'(e0[i]), 32'(e1[i]), el[i]}) begin
                    n_bad++;
                    $display("FAIL midrst%0d_result[%0d]: got %0d/%0d last=%0b, expected %0d/%0d last=%0b",
                             pass, i, $signed(o0[i]), $signed(o1[i]), ol[i], e0[i], e1[i], el[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stride1();
        test_stride2();
        test_relu();
        test_backpressure();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
Streaming successor of the fixed 28x28 conv stage. Accepts one pixel per handshake beat in raster order and keeps two line buffers to form a 3x3 window. Computes OUT_CH parallel 3x3 convolutions with per-channel bias, with selectable stride (1/2) and optional ReLU. Sits between the pixel source and the FC stage, using valid/ready on both sides.

Parameters:
IMG_W, 28, image width in pixels (>=3)
IMG_H, 28, image height in pixels (>=3)
DATA_W, 8, pixel/weight/bias width
OUT_CH, 2, number of output channels (filters)
ACC_W, 32, per-channel result width (signed)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cfg_we  in  1  config write strobe
i_cfg_addr  in  $clog2(OUT_CH*10)  addr ch*9+tap = weight (tap = 3*dy+dx); OUT_CH*9+ch = bias
i_cfg_data  in  DATA_W  signed weight/bias value
i_relu_en  in  1  ReLU mode, sampled at frame start
i_stride2  in  1  stride-2 mode, sampled at frame start
i_pre_valid  in  1  pixel valid
o_pre_ready  out  1  engine can accept pixel
i_data  in  DATA_W  unsigned pixel
o_post_valid  out  1  result valid
i_post_ready  in  1  downstream accepts result
o_res  out  OUT_CH*ACC_W  channel k at [k*ACC_W +: ACC_W]
o_last  out  1  marks last result of frame (qualified by o_post_valid)

Behaviour:
- Reset (async, i_rst_n=0): o_post_valid=0, o_res=0, o_last=0, row/col counters=0, all weights/biases=0, latched modes=0. Line buffer contents are not reset; stale data is masked by the counters.
- Pixel beat = i_pre_valid && o_pre_ready. o_pre_ready = !o_post_valid || i_post_ready; it is combinational and independent of i_pre_valid.
- Counters: col increments per beat. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0 and the frame ends.
- Modes: i_relu_en and i_stride2 are latched on the beat at row=0,col=0. They hold for the whole frame; mid-frame changes are ignored.
- Window completes on a beat with row>=2 and col>=2. In stride-2 mode it additionally requires (row-2) and (col-2) to be even. Window taps: rows row-2..row, cols col-2..col. Tap (dy,dx) is the pixel at (row-2+dy, col-2+dx).
- Per channel: sum = bias + sum of w[tap]*pixel. Pixel is zero-extended and weight/bias sign-extended to ACC_W. The sum is signed, wraps mod 2^ACC_W, and has no saturation. ReLU: a negative sum becomes 0.
- Latency: a window-completing beat in cycle N gives o_post_valid=1 in cycle N+1, with o_res registered.
- o_last=1 with the result whose window completes at row=IMG_H-1 and the last stride-valid column.
- Output hold: while o_post_valid && !i_post_ready, o_res and o_last are stable and o_pre_ready=0.
- Output drain: if the output is drained and a new window completes in the same cycle, o_post_valid stays 1 with the new data. If the output is drained with no new window, o_post_valid drops to 0.
- Non-window beats never touch the output register.
- Results per frame: stride 1 gives (IMG_W-2)*(IMG_H-2); stride 2 gives ceil((IMG_W-2)/2)*ceil((IMG_H-2)/2).
- Config writes take effect the cycle after i_cfg_we. Addresses >= OUT_CH*10 are ignored. Writing during a frame is legal but gives mixed-weight results; the bench writes between frames only.
- Reset mid-frame: the next accepted pixel is treated as (0,0). Any pending result is dropped.

Test Plan:
- Stride 1, ReLU off, pixel(r,c)=c, ch0 w[i]=i with bias 1, ch1 all w=1 with bias 0. Required: 676 results. ch0=36c+43 (first 43, last of row 943); ch1=9c+9. o_last only on the 676th result.
- Stride 2, same data. Required: 169 results. Row values for c=0,2,..,24: ch0 = 43, 115, .., 907. o_last on the 169th.
- ch0 all w=-1, bias 0. ReLU off: first result ch0 = -9 (0xFFFFFFF7). ReLU on, next frame: every ch0 result = 0.
- Backpressure: hold i_post_ready=0 for 20 cycles at the first result. Required: o_res stays 43, o_pre_ready=0, no pixel is lost. After release, the sequence matches the stride-1 run exactly.
- Random i_pre_valid and i_post_ready gaps (50%). Results must match the reference model in order and count.
- Assert i_rst_n=0 at pixel 300, then release and stream a full frame. Required: o_post_valid=0 and weights=0 during reset. After reconfiguring, the 676 results are correct.
